// File: rtl/flag_sync_multi.sv
// Multi-channel event synchroniser: flop chain, edge detect, pulse plus sticky pending/overrun.
// Optional per-channel saturating event counters are built when FLAG_SYNC_COUNT_EN is defined.
module flag_sync_multi #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int CNT_W       = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       async_i,
  input  logic [CHANNELS-1:0]       ack_i,
  output logic [CHANNELS-1:0]       pulse_o,
  output logic [CHANNELS-1:0]       pending_o,
  output logic [CHANNELS-1:0]       overrun_o,
  output logic                      ready_o,
  output logic [CHANNELS*CNT_W-1:0] count_o
);

  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_r;
  logic [CHANNELS-1:0] sync_last_s;
  logic [CHANNELS-1:0] hist_r;
  logic [CHANNELS-1:0] ev_s;
  logic [CHANNELS-1:0] pulse_r;
  logic [CHANNELS-1:0] pending_r;
  logic [CHANNELS-1:0] overrun_r;
  logic [CHANNELS-1:0] pending_nxt_s;
  logic [CHANNELS-1:0] overrun_nxt_s;
  logic [2:0]          prime_cnt_r;
  logic                ready_r;

  assign sync_last_s = sync_r[SYNC_STAGES-1];

  // synchroniser chain and edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      hist_r <= {CHANNELS{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_i};
      hist_r <= sync_last_s;
    end
  end

  // prime window: lets hist catch up with input levels present at reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt_r <= 3'd0;
      ready_r     <= 1'b0;
    end else if (!ready_r) begin
      prime_cnt_r <= prime_cnt_r + 3'd1;
      ready_r     <= (prime_cnt_r == PRIME_LAST);
    end else begin
      prime_cnt_r <= prime_cnt_r;
      ready_r     <= 1'b1;
    end
  end

  // event detection, masked during the prime window
  always_comb begin
    ev_s = {CHANNELS{1'b0}};
    if (!ready_r) begin
      ev_s = {CHANNELS{1'b0}};
    end else if (EDGE_MODE == 0) begin
      ev_s = sync_last_s ^ hist_r;
    end else begin
      ev_s = sync_last_s & ~hist_r;
    end
  end

  // handshake next-state: a new event wins over a coincident ack
  always_comb begin
    pending_nxt_s = ev_s | (pending_r & ~ack_i);
    overrun_nxt_s = (ev_s & pending_r & ~ack_i) | (overrun_r & ~ack_i);
  end

  // registered strobe and sticky flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_r   <= {CHANNELS{1'b0}};
      pending_r <= {CHANNELS{1'b0}};
      overrun_r <= {CHANNELS{1'b0}};
    end else begin
      pulse_r   <= ev_s;
      pending_r <= pending_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

  assign pulse_o   = pulse_r;
  assign pending_o = pending_r;
  assign overrun_o = overrun_r;
  assign ready_o   = ready_r;

`ifdef FLAG_SYNC_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_r;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_nxt_s;

  // saturating per-channel counters; ack restarts from the coincident event, if any
  always_comb begin
    cnt_nxt_s = cnt_r;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ack_i[i]) begin
        cnt_nxt_s[i] = ev_s[i] ? CNT_W'(1) : CNT_W'(0);
      end else if (ev_s[i] && (cnt_r[i] != CNT_MAX)) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign count_o = cnt_r;
`else
  assign count_o = {(CHANNELS*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_flag_sync_multi.sv
// Directed bench for flag_sync_multi: toggle-mode instance plus a rising-edge-mode instance.
module tb_flag_sync_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  async_a, ack_a, pulse_a, pending_a, overrun_a;
  logic [7:0]  async_b, ack_b, pulse_b, pending_b, overrun_b;
  logic        ready_a, ready_b;
  logic [31:0] count_a, count_b;
  int          n_cmp = 0;
  int          n_err = 0;

  flag_sync_multi #(.CHANNELS(8), .SYNC_STAGES(2), .EDGE_MODE(0), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .async_i(async_a), .ack_i(ack_a),
    .pulse_o(pulse_a), .pending_o(pending_a), .overrun_o(overrun_a),
    .ready_o(ready_a), .count_o(count_a));

  flag_sync_multi #(.CHANNELS(8), .SYNC_STAGES(2), .EDGE_MODE(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .async_i(async_b), .ack_i(ack_b),
    .pulse_o(pulse_b), .pending_o(pending_b), .overrun_o(overrun_b),
    .ready_o(ready_b), .count_o(count_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    async_a = 8'hFF;
    async_b = 8'h00;
    ack_a   = 8'h00;
    ack_b   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse", pulse_a, 32'h0);
    check("rst_pending", pending_a, 32'h0);
    check("rst_overrun", overrun_a, 32'h0);
    check("rst_ready", ready_a, 32'h0);
    check("rst_count", count_a, 32'h0);

    reset_n = 1'b1;
    tick();
    check("prime1_ready", ready_a, 32'h0);
    tick();
    check("prime2_ready", ready_a, 32'h0);
    check("prime2_pulse", pulse_a, 32'h0);
    tick();
    check("prime3_ready", ready_a, 32'h1);
    check("prime3_pulse", pulse_a, 32'h0);
    check("prime3_pending", pending_a, 32'h0);
    tick();
    check("prime4_pulse", pulse_a, 32'h0);
    check("prime4_pending", pending_a, 32'h0);
    check("prime4_ready_b", ready_b, 32'h1);

    // every channel falls at once
    async_a = 8'h00;
    tick(); tick();
    check("all_early", pulse_a, 32'h0);
    tick();
    check("all_pulse", pulse_a, 32'hFF);
    check("all_pending", pending_a, 32'hFF);
    tick();
    check("all_pulse_end", pulse_a, 32'h0);
    check("all_pending_hold", pending_a, 32'hFF);
    check("all_overrun", overrun_a, 32'h0);
    ack_a = 8'hFF;
    tick();
    ack_a = 8'h00;
    check("all_ack", pending_a, 32'h0);

    // ch3 rises
    async_a = 8'h08;
    tick(); tick();
    check("ch3_early", pulse_a, 32'h0);
    tick();
    check("ch3_pulse", pulse_a, 32'h08);
    check("ch3_pending", pending_a, 32'h08);
    tick();
    check("ch3_pulse_end", pulse_a, 32'h0);
    check("ch3_pending_hold", pending_a, 32'h08);
    ack_a = 8'h08;
    tick();
    ack_a = 8'h00;
    check("ch3_ack", pending_a, 32'h0);

    // ack on idle channels
    ack_a = 8'hFF;
    tick();
    ack_a = 8'h00;
    check("idle_ack_pending", pending_a, 32'h0);
    check("idle_ack_overrun", overrun_a, 32'h0);
    check("idle_ack_pulse", pulse_a, 32'h0);

    // two unacknowledged events on ch0
    async_a = 8'h09;
    tick(); tick(); tick();
    check("ov_first_pulse", pulse_a, 32'h01);
    check("ov_first_overrun", overrun_a, 32'h0);
    tick();
    async_a = 8'h08;
    tick(); tick(); tick();
    check("ov_second_pulse", pulse_a, 32'h01);
    check("ov_pending", pending_a, 32'h01);
    check("ov_overrun", overrun_a, 32'h01);
    ack_a = 8'h01;
    tick();
    ack_a = 8'h00;
    check("ov_ack_pending", pending_a, 32'h0);
    check("ov_ack_overrun", overrun_a, 32'h0);

    // ch5: ack coincident with a new event
    async_a = 8'h28;
    tick(); tick(); tick();
    check("c5_first_pending", pending_a, 32'h20);
    tick();
    async_a = 8'h08;
    tick(); tick();
    ack_a = 8'h20;
    tick();
    check("c5_pulse", pulse_a, 32'h20);
    check("c5_pending", pending_a, 32'h20);
    check("c5_overrun", overrun_a, 32'h0);
    ack_a = 8'h00;
    tick();
    check("c5_pending_hold", pending_a, 32'h20);
    check("c5_overrun_hold", overrun_a, 32'h0);
    ack_a = 8'h20;
    tick();
    ack_a = 8'h00;
    check("c5_ack", pending_a, 32'h0);

    // rising-edge mode: ch1 high then low
    async_b = 8'h02;
    tick(); tick(); tick();
    check("lvl_rise_pulse", pulse_b, 32'h02);
    check("lvl_rise_pending", pending_b, 32'h02);
    tick();
    check("lvl_rise_end", pulse_b, 32'h0);
    async_b = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("lvl_fall_none", pulse_b, 32'h0);
    end
    check("lvl_pending_hold", pending_b, 32'h02);

    // 20 unacknowledged events on ch2
    for (int k = 0; k < 20; k++) begin
      async_a = async_a ^ 8'h04;
      tick(); tick(); tick(); tick();
`ifdef FLAG_SYNC_COUNT_EN
      if (k == 2) check("cnt_three", count_a[11:8], 32'd3);
`endif
    end
    check("cnt_pending", pending_a, 32'h04);
    check("cnt_overrun", overrun_a, 32'h04);
`ifdef FLAG_SYNC_COUNT_EN
    check("cnt_saturated", count_a[11:8], 32'd15);
    check("cnt_others", count_a & 32'hFFFF_F0FF, 32'h0);
`else
    check("cnt_absent", count_a, 32'h0);
`endif
    ack_a = 8'h04;
    tick();
    ack_a = 8'h00;
    check("cnt_ack_pending", pending_a, 32'h0);
    check("cnt_ack_count", count_a, 32'h0);

    // reset mid-operation with a pending event and non-zero inputs
    async_a = 8'h0C;
    tick(); tick(); tick();
    check("mid_pending_before", pending_a, 32'h04);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_pending", pending_a, 32'h0);
    check("mid_rst_ready", ready_a, 32'h0);
    check("mid_rst_pending_b", pending_b, 32'h0);
    reset_n = 1'b1;
    tick();
    check("mid_prime1_ready", ready_a, 32'h0);
    tick();
    check("mid_prime2_ready", ready_a, 32'h0);
    tick();
    check("mid_prime3_ready", ready_a, 32'h1);
    tick(); tick();
    check("mid_no_pulse", pulse_a, 32'h0);
    check("mid_no_pending", pending_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
